// File: rtl/sb_rmw_unit_pkg.sv
// rtl/sb_rmw_unit_pkg.sv - shared types and constants for the store-byte engine
package sb_rmw_unit_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } rmw_state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/sb_rmw_unit_if.sv
// rtl/sb_rmw_unit_if.sv - request and data-memory port bundle of the store-byte engine
interface sb_rmw_unit_if #(
    parameter int ADDR_W = 32
);
    import sb_rmw_unit_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] rt_value;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_rd_en;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_wr_en;
    logic [WORD_W-1:0] mem_wdata;
    logic              done;

    modport slave (
        input  req_valid, req_addr, rt_value, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done
    );

    modport master (
        output req_valid, req_addr, rt_value, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done
    );

endinterface

// File: rtl/sb_rmw_unit_byte_lane_merge.sv
// rtl/sb_rmw_unit_byte_lane_merge.sv - little-endian byte insert into a 32-bit word
module byte_lane_merge
    import sb_rmw_unit_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic [1:0]        lane,
    output logic [WORD_W-1:0] merged
);

    always_comb begin
        merged = word_in;
        case (lane)
            LANE0: merged[0*BYTE_W +: BYTE_W] = byte_in;
            LANE1: merged[1*BYTE_W +: BYTE_W] = byte_in;
            LANE2: merged[2*BYTE_W +: BYTE_W] = byte_in;
            LANE3: merged[3*BYTE_W +: BYTE_W] = byte_in;
            default: merged = word_in;
        endcase
    end

endmodule

// File: rtl/sb_rmw_unit.sv
// rtl/sb_rmw_unit.sv - store-byte read-modify-write engine on a word-organised memory
module sb_rmw_unit
    import sb_rmw_unit_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    sb_rmw_unit_if.slave bus
);

    rmw_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] merged;
    logic              ready;
    logic              rd_en;
    logic              wr_en;
    logic              unused_rt_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            byte_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lane_q  <= lane_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = READ;
            READ:    state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured only at acceptance so the requester may change them afterwards.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        lane_d = lane_q;
        byte_d = byte_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr[ADDR_W-1:2];
                    lane_d = bus.req_addr[1:0];
                    byte_d = bus.rt_value[BYTE_W-1:0];
                end
            end
            READ: cnt_d = CNT_W'(RD_LATENCY - 1);
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d = bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            READ:    rd_en = 1'b1;
            WRITE:   wr_en = 1'b1;
            default: ;
        endcase
    end

    byte_lane_merge u_merge (
        .word_in (data_q),
        .byte_in (byte_q),
        .lane    (lane_q),
        .merged  (merged)
    );

    assign unused_rt_hi  = ^bus.rt_value[WORD_W-1:BYTE_W];

    assign bus.req_ready = ready;
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_wr_en = wr_en;
    assign bus.done      = wr_en;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = merged;

endmodule

// File: tb/tb_sb_rmw_unit.sv
// tb/tb_sb_rmw_unit.sv - store-byte engine bench with a cycle-level behavioural model
module tb_sb_rmw_unit;

    localparam int LAT = 3;
    localparam int AW  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sb_rmw_unit_if #(.ADDR_W(AW)) bus ();

    sb_rmw_unit #(.RD_LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    logic [31:0] mem     [bit [29:0]];
    logic [31:0] ref_mem [bit [29:0]];
    int          rq_due  [$];
    logic [31:0] rq_dat  [$];

    bit        armed    = 1'b0;
    bit        busy     = 1'b0;
    bit        zero_win = 1'b0;
    int        acc_cyc  = 0;
    bit [29:0] m_word;
    bit [1:0]  m_lane;
    bit [7:0]  m_byte;

    int          rd_count    = 0;
    int          wr_count    = 0;
    int          last_rd_cyc = -1;
    int          last_wr_cyc = -1;
    bit [29:0]   last_rd_addr;
    bit [29:0]   last_wr_addr;
    logic [31:0] last_wr_data;
    bit          ready_hist [0:4095];

    function automatic logic [31:0] fill(input bit [29:0] w);
        return {w[15:0], ~w[15:0]};
    endfunction

    function automatic logic [31:0] rd_mem(input bit [29:0] w);
        return mem.exists(w) ? mem[w] : fill(w);
    endfunction

    function automatic logic [31:0] rd_ref(input bit [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : fill(w);
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input bit [1:0] lane, input bit [7:0] b);
        int sh;
        sh = 8 * int'(lane);
        return (w & ~(32'h0000_00FF << sh)) | ({24'h0, b} << sh);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic preload(input bit [29:0] w, input logic [31:0] d);
        mem[w]     = d;
        ref_mem[w] = d;
    endtask

    // Read data is presented for exactly one cycle, RD_LATENCY after the strobe; junk otherwise.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        while (rq_due.size() > 0 && rq_due[0] < cyc) begin
            void'(rq_due.pop_front());
            void'(rq_dat.pop_front());
        end
        if (rq_due.size() > 0 && rq_due[0] == cyc) begin
            bus.mem_rdata = rq_dat.pop_front();
            void'(rq_due.pop_front());
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        bit          e_rd;
        bit          e_wr;
        logic [31:0] e_data;
        if (armed) begin
            e_rd   = busy && (cyc == acc_cyc + 1);
            e_wr   = busy && (cyc == acc_cyc + 2 + LAT);
            e_data = put_byte(rd_ref(m_word), m_lane, m_byte);
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd));
            chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(e_wr));
            chk("done",      32'(bus.done),      32'(e_wr));
            if (e_rd || e_wr) chk("mem_addr", 32'(bus.mem_addr), 32'(m_word));
            if (e_wr) chk("mem_wdata", bus.mem_wdata, e_data);
            if (zero_win) begin
                chk("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
                chk("rst_mem_wdata", bus.mem_wdata,     32'd0);
            end
            if (bus.mem_rd_en === 1'b1) begin
                rq_due.push_back(cyc + LAT);
                rq_dat.push_back(rd_mem(bus.mem_addr));
                rd_count++;
                last_rd_cyc  = cyc;
                last_rd_addr = bus.mem_addr;
            end
            if (bus.mem_wr_en === 1'b1) begin
                mem[bus.mem_addr] = bus.mem_wdata;
                wr_count++;
                last_wr_cyc  = cyc;
                last_wr_addr = bus.mem_addr;
                last_wr_data = bus.mem_wdata;
            end
            if (cyc < 4096) ready_hist[cyc] = bus.req_ready;
        end
        if (reset) begin
            busy     = 1'b0;
            zero_win = 1'b1;
            armed    = 1'b1;
        end else if (armed) begin
            if (busy && cyc == acc_cyc + 2 + LAT) begin
                ref_mem[m_word] = put_byte(rd_ref(m_word), m_lane, m_byte);
                busy = 1'b0;
            end else if (!busy && bus.req_valid) begin
                busy     = 1'b1;
                acc_cyc  = cyc;
                m_word   = bus.req_addr[31:2];
                m_lane   = bus.req_addr[1:0];
                m_byte   = bus.rt_value[7:0];
                zero_win = 1'b0;
            end
        end
    end

    task automatic wait_accept(output int acc);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        acc  = -1;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = bus.req_ready;
            n++;
        end
        chk("accept", 32'(seen), 32'd1);
        acc = cyc;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] v, output int acc);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rt_value  = v;
        wait_accept(acc);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.rt_value  = $urandom;
    endtask

    task automatic settle();
        repeat (LAT + 3) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a, a2, r0, w0;
        bit [1:0]    lanes [3];
        logic [31:0] exp_w [3];
        bit [29:0]   pw;
        logic [31:0] pa;

        lanes[0] = 2'd0; exp_w[0] = 32'h1122_335A;
        lanes[1] = 2'd1; exp_w[1] = 32'h1122_5A44;
        lanes[2] = 2'd3; exp_w[2] = 32'h5A22_3344;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rt_value  = '0;
        bus.mem_rdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rd_en", 32'(bus.mem_rd_en), 32'd0);
        chk("reset_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("reset_done",  32'(bus.done),      32'd0);
        chk("reset_addr",  32'(bus.mem_addr),  32'd0);
        chk("reset_wdata", bus.mem_wdata,      32'd0);
        @(posedge clk); #2;

        // lane 2 store with latency profile
        preload(30'h40, 32'h1122_3344);
        r0 = rd_count; w0 = wr_count;
        store(32'h0000_0102, 32'hFFFF_FFAB, a);
        settle();
        chk("t1_rd_once",   32'(rd_count - r0), 32'd1);
        chk("t1_wr_once",   32'(wr_count - w0), 32'd1);
        chk("t1_rd_addr",   32'(last_rd_addr),  32'h40);
        chk("t1_wr_addr",   32'(last_wr_addr),  32'h40);
        chk("t1_wdata",     last_wr_data,       32'h11AB_3344);
        chk("t1_rd_cycle",  32'(last_rd_cyc - a), 32'd1);
        chk("t1_wr_cycle",  32'(last_wr_cyc - a), 32'd5);
        for (int k = 1; k <= 5; k++) chk("t1_ready_low", 32'(ready_hist[a + k]), 32'd0);
        chk("t1_ready_back", 32'(ready_hist[a + 6]), 32'd1);

        for (int i = 0; i < 3; i++) begin
            preload(30'h40, 32'h1122_3344);
            store({30'h40, lanes[i]}, 32'hC3C3_C35A, a);
            settle();
            chk("t2_lane_wdata", last_wr_data, exp_w[i]);
        end

        // two requests with req_valid never dropped
        preload(30'h40, 32'h1122_3344);
        preload(30'h41, 32'h5566_7788);
        r0 = rd_count; w0 = wr_count;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0101;
        bus.rt_value  = 32'hABCD_EF77;
        wait_accept(a);
        @(posedge clk); #2;
        bus.req_addr  = 32'h0000_0107;
        bus.rt_value  = 32'h1234_5699;
        wait_accept(a2);
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        settle();
        chk("t3_rd_pairs",   32'(rd_count - r0), 32'd2);
        chk("t3_wr_pairs",   32'(wr_count - w0), 32'd2);
        chk("t3_gap",        32'(a2 - a),        32'd6);
        chk("t3_rd2_cycle",  32'(last_rd_cyc - a2), 32'd1);
        chk("t3_word0",      rd_mem(30'h40),     32'h1122_7744);
        chk("t3_word1",      rd_mem(30'h41),     32'h9966_7788);

        // reset while waiting on read data
        preload(30'h40, 32'h1122_3344);
        w0 = wr_count;
        store(32'h0000_0102, 32'h0000_00AB, a);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_ready_after_rst", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #2;
        settle();
        chk("t4_no_write", 32'(wr_count - w0), 32'd0);
        chk("t4_word",     rd_mem(30'h40),     32'h1122_3344);

        // top-of-memory address
        preload(30'h3FFF_FFFF, 32'hDEAD_BEEF);
        store(32'hFFFF_FFFF, 32'h1234_5600, a);
        settle();
        chk("t5_rd_addr", 32'(last_rd_addr), 32'h3FFF_FFFF);
        chk("t5_wr_addr", 32'(last_wr_addr), 32'h3FFF_FFFF);
        chk("t5_wdata",   last_wr_data,      32'h00AD_BEEF);

        // randomized stores into a small word pool with occasional mid-flight reset
        for (int i = 0; i < 80; i++) begin
            pw = 30'h80 + 30'($urandom_range(0, 3));
            pa = {pw, 2'($urandom_range(0, 3))};
            store(pa, $urandom, a);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, LAT)) @(posedge clk);
                #2;
                reset = 1'b1;
                @(posedge clk); #2;
                reset = 1'b0;
            end
            settle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
        end
        for (int w = 0; w < 4; w++) begin
            pw = 30'h80 + 30'(w);
            chk("pool_word", rd_mem(pw), rd_ref(pw));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
